// File: rtl/rpc_axi_cmd_splitter.sv
// Splits AXI INCR bursts into RPC word commands that never cross a DRAM page or exceed MAX_WORDS.
// Optional statistics counters are enabled by defining RPC_CMD_SPLIT_STATS_EN.
module rpc_axi_cmd_splitter #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int PAGE_WORDS = 64,
    parameter int MAX_WORDS  = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [ADDR_WIDTH-1:0]         in_addr_i,
    input  logic [7:0]                    in_len_i,
    input  logic [2:0]                    in_size_i,
    input  logic [1:0]                    in_burst_i,
    input  logic                          in_write_i,
    input  logic [ID_WIDTH-1:0]           in_id_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [ADDR_WIDTH-6:0]         out_waddr_o,
    output logic [$clog2(MAX_WORDS)-1:0]  out_wlen_o,
    output logic                          out_write_o,
    output logic [ID_WIDTH-1:0]           out_id_o,
    output logic                          out_last_o,
    output logic                          err_o
`ifdef RPC_CMD_SPLIT_STATS_EN
    ,
    output logic [31:0]                   stat_frags_o,
    output logic [31:0]                   stat_bursts_o
`endif
);
    localparam int WA_W  = ADDR_WIDTH - 5;
    localparam int REM_W = ADDR_WIDTH - 4;
    localparam int LEN_W = $clog2(MAX_WORDS);
    localparam int PG_W  = $clog2(PAGE_WORDS);
    localparam logic [ADDR_WIDTH:0] ONE_A   = 1;
    localparam logic [REM_W-1:0]    REM_ONE = 1;
    localparam logic [REM_W-1:0]    MAXW_R  = REM_W'(MAX_WORDS);
    localparam logic [1:0]          BURST_INCR = 2'b01;

    typedef enum logic {IDLE, SPLIT} state_t;
    state_t state_q, state_d;

    logic [WA_W-1:0]     cur_q;
    logic [REM_W-1:0]    rem_q;
    logic [ID_WIDTH-1:0] id_q;
    logic                write_q;
    logic                err_q;

    logic                accept, is_incr, fire;
    logic [ADDR_WIDTH:0] beats, nbytes, end_byte;
    logic [WA_W-1:0]     start_w;
    logic [REM_W-1:0]    end_w, rem_init;
    logic [REM_W-1:0]    room, frag;
    logic                frag_last;

    // Burst extent in words; one extra bit keeps the end address from wrapping.
    assign beats    = (ADDR_WIDTH+1)'(in_len_i) + ONE_A;
    assign nbytes   = beats << in_size_i;
    assign end_byte = {1'b0, in_addr_i} + nbytes - ONE_A;
    assign start_w  = WA_W'(in_addr_i >> 5);
    assign end_w    = REM_W'(end_byte >> 5);
    assign rem_init = end_w - REM_W'(start_w) + REM_ONE;

    assign is_incr = (in_burst_i == BURST_INCR);
    assign accept  = in_valid_i && in_ready_o;
    assign fire    = out_valid_o && out_ready_i;

    // Fragment size from registered state only, so out_* never sees in_*.
    assign room = REM_W'(PAGE_WORDS) - REM_W'(cur_q[PG_W-1:0]);
    always_comb begin
        frag = rem_q;
        if (room < frag)   frag = room;
        if (MAXW_R < frag) frag = MAXW_R;
    end
    assign frag_last = (frag == rem_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid_i && is_incr) state_d = SPLIT;
            SPLIT:   if (out_ready_i && frag_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_waddr_o = '0;
        out_wlen_o  = '0;
        out_write_o = 1'b0;
        out_id_o    = '0;
        out_last_o  = 1'b0;
        case (state_q)
            IDLE: in_ready_o = !rst_i;
            SPLIT: begin
                out_valid_o = 1'b1;
                out_waddr_o = cur_q;
                out_wlen_o  = LEN_W'(frag - REM_ONE);
                out_write_o = write_q;
                out_id_o    = id_q;
                out_last_o  = frag_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur_q   <= '0;
            rem_q   <= '0;
            id_q    <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && !is_incr;
            if (accept && is_incr) begin
                cur_q   <= start_w;
                rem_q   <= rem_init;
                id_q    <= in_id_i;
                write_q <= in_write_i;
            end else if (fire) begin
                cur_q <= cur_q + WA_W'(frag);
                rem_q <= rem_q - frag;
            end
        end
    end

    assign err_o = err_q;

`ifdef RPC_CMD_SPLIT_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_frags_o  <= '0;
            stat_bursts_o <= '0;
        end else begin
            if (fire && (stat_frags_o != '1))
                stat_frags_o <= stat_frags_o + 32'd1;
            if (accept && is_incr && (stat_bursts_o != '1))
                stat_bursts_o <= stat_bursts_o + 32'd1;
        end
    end
`endif

endmodule
